distram_fwft_fifo: RTL and testbench

DISTRAM_FWFT_FIFO -- requirements
Module: distram_fwft_fifo

---
 rtl/fifo_pkg.sv | 17 +
 rtl/distram_2port.sv | 37 +++
 rtl/distram_fwft_fifo.sv | 177 +++++++++++++++++
 tb/tb_distram_fwft_fifo.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the distributed-RAM FWFT FIFO family.
// Holds the default geometry, the read-latency default and the width of the
// optional statistics counters enabled by DISTRAM_FIFO_STATS_EN.
package fifo_pkg;

    localparam int FIFO_DEFAULT_WIDTH      = 64;
    localparam int FIFO_DEFAULT_DEPTH_BITS = 5;
    localparam int FIFO_DEFAULT_RD_LATENCY = 1;
    localparam int FIFO_STATS_CNT_WIDTH    = 32;

    // The prefetch buffer must absorb every read that can be in flight
    // plus the word currently presented at the head.
    function automatic int prefetch_depth(input int rd_latency);
        return rd_latency + 1;
    endfunction

endpackage

// File: rtl/distram_2port.sv
// Simple dual-port distributed RAM: synchronous write, asynchronous read
// followed by RD_LATENCY output registers. The pipeline registers carry no
// reset; validity of the words moving through them is tracked by the user.
module distram_2port #(
    parameter int WIDTH      = 64,
    parameter int ADDR_BITS  = 5,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem     [2**ADDR_BITS];
    logic [WIDTH-1:0] rd_pipe [RD_LATENCY];

    // Write port: store the word at the write address when enabled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: capture the addressed word and push it down the pipeline.
    always_ff @(posedge clk) begin
        rd_pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LATENCY; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rd_data = rd_pipe[RD_LATENCY-1];

endmodule

// File: rtl/distram_fwft_fifo.sv
// First-word-fall-through FIFO built on a pipelined distributed RAM.
// A small prefetch buffer hides the RAM read latency so the head word is
// always presented combinationally with rd_valid.
// Optional feature: define DISTRAM_FIFO_STATS_EN to add drop_cnt and
// peak_count statistics outputs.
module distram_fwft_fifo
    import fifo_pkg::*;
#(
    parameter int FIFO_WIDTH                = FIFO_DEFAULT_WIDTH,
    parameter int FIFO_DEPTH_BITS           = FIFO_DEFAULT_DEPTH_BITS,
    parameter int FIFO_ALMOSTFULL_THRESHOLD = 2**FIFO_DEPTH_BITS - 8,
    parameter int RD_LATENCY                = FIFO_DEFAULT_RD_LATENCY
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_WIDTH-1:0]      wr_data,
    output logic                       full,
    output logic                       almostfull,
    output logic [FIFO_WIDTH-1:0]      rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [FIFO_DEPTH_BITS+1:0] count,
    output logic                       overflow
`ifdef DISTRAM_FIFO_STATS_EN
    ,
    output logic [FIFO_STATS_CNT_WIDTH-1:0] drop_cnt,
    output logic [FIFO_DEPTH_BITS+1:0]      peak_count
`endif
);

    localparam int PW        = FIFO_DEPTH_BITS + 1;
    localparam int CW        = FIFO_DEPTH_BITS + 2;
    localparam int BUF_DEPTH = prefetch_depth(RD_LATENCY);
    localparam logic [CW-1:0] AF_THRESHOLD = CW'(FIFO_ALMOSTFULL_THRESHOLD);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  ram_empty;
    logic                  wr_accept;
    logic                  rd_issue;
    logic                  pop;
    logic                  arrive;
    logic [RD_LATENCY-1:0] in_flight;
    logic [1:0]            in_flight_cnt;
    logic [1:0]            buf_cnt;
    logic [1:0]            buf_head;
    logic [1:0]            buf_tail;
    logic [FIFO_WIDTH-1:0] buf_mem [4];
    logic [FIFO_WIDTH-1:0] ram_rd_data;
    logic [CW-1:0]         count_next;

    // Circular index advance within the prefetch buffer.
    function automatic logic [1:0] buf_next(input logic [1:0] idx);
        return (idx == 2'(BUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign ram_empty = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                       (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign wr_accept = wr_en && !full;
    assign rd_valid  = (buf_cnt != 2'd0);
    assign rd_data   = buf_mem[buf_head];
    assign pop       = rd_valid && rd_ready;
    assign arrive    = in_flight[RD_LATENCY-1];

    // Number of RAM reads currently travelling through the output pipeline.
    always_comb begin
        in_flight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight_cnt = in_flight_cnt + 2'(in_flight[i]);
        end
    end

    // Issue a read when the buffer can hold it alongside every read already
    // in flight; a same-cycle pop frees a slot, which keeps streaming at one
    // word per cycle.
    always_comb begin
        rd_issue = !ram_empty &&
                   (({1'b0, buf_cnt} + {1'b0, in_flight_cnt}) <
                    (3'(BUF_DEPTH) + {2'b0, pop}));
    end

    distram_2port #(
        .WIDTH      (FIFO_WIDTH),
        .ADDR_BITS  (FIFO_DEPTH_BITS),
        .RD_LATENCY (RD_LATENCY)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[PW-2:0]),
        .wr_data (wr_data),
        .rd_addr (rd_ptr[PW-2:0]),
        .rd_data (ram_rd_data)
    );

    // RAM pointers wrap naturally over PW bits; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + PW'(1);
            if (rd_issue)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Valid marker shifting alongside each word in the RAM output pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_flight <= '0;
        end else begin
            in_flight[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                in_flight[i] <= in_flight[i-1];
            end
        end
    end

    // Prefetch buffer storage: capture each word as it leaves the RAM pipeline.
    always_ff @(posedge clk) begin
        if (arrive) begin
            buf_mem[buf_tail] <= ram_rd_data;
        end
    end

    // Prefetch buffer bookkeeping: head/tail indices and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= '0;
        end else begin
            if (arrive) buf_tail <= buf_next(buf_tail);
            if (pop)    buf_head <= buf_next(buf_head);
            if (arrive && !pop)      buf_cnt <= buf_cnt + 2'd1;
            else if (!arrive && pop) buf_cnt <= buf_cnt - 2'd1;
        end
    end

    // Total occupancy moves only on accepted writes and pops; internal moves
    // from RAM to the buffer leave it unchanged.
    always_comb begin
        count_next = count;
        if (wr_accept && !pop)      count_next = count + CW'(1);
        else if (!wr_accept && pop) count_next = count - CW'(1);
    end

    // Occupancy, registered threshold flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            almostfull <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count      <= count_next;
            almostfull <= (count > AF_THRESHOLD);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

`ifdef DISTRAM_FIFO_STATS_EN
    // Saturating dropped-write counter and occupancy high-water mark.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt   <= '0;
            peak_count <= '0;
        end else begin
            if (wr_en && full && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + FIFO_STATS_CNT_WIDTH'(1);
            end
            if (count_next > peak_count) peak_count <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_distram_fwft_fifo.sv
// Scoreboard bench for distram_fwft_fifo at default parameters.
// Stimulus pushes expected words into a queue; a negedge monitor pops and
// compares every accepted head word and checks stability while stalled.
module tb_distram_fwft_fifo;

    localparam int W   = 64;
    localparam int DB  = 5;
    localparam int L   = 1;
    localparam int CAP = 2**DB + L + 1;
    localparam int AF  = 2**DB - 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          rd_ready = 1'b0;
    logic          full;
    logic          almostfull;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [DB+1:0] count;
    logic          overflow;
`ifdef DISTRAM_FIFO_STATS_EN
    logic [31:0]   drop_cnt;
    logic [DB+1:0] peak_count;
`endif

    int           checks = 0;
    int           errors = 0;
    int           pops = 0;
    logic [W-1:0] sb [$];
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;

    distram_fwft_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .almostfull (almostfull),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .overflow   (overflow)
`ifdef DISTRAM_FIFO_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .peak_count (peak_count)
`endif
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; accepted words enter the scoreboard.
    task automatic applyStimulus(input logic we, input logic [W-1:0] data,
                                 input logic rr, input logic expect_accept);
        wr_en    = we;
        wr_data  = data;
        rd_ready = rr;
        if (we && expect_accept) sb.push_back(data);
        wait_cycle();
    endtask

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        wr_en    = 1'b0;
        rd_ready = 1'b0;
        sb.delete();
        repeat (cycles) wait_cycle();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        wr_en    = 1'b0;
        rd_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            wait_cycle();
            n++;
        end
        checkOutput({name, "_left"}, 64'(sb.size()), 64'd0);
        sb.delete();
        wait_cycle();
        wait_cycle();
        checkOutput({name, "_valid"}, 64'(rd_valid), 64'd0);
        checkOutput({name, "_count"}, 64'(count), 64'd0);
        rd_ready = 1'b0;
    endtask

    // Monitor: compare each popped head word and check hold-while-stalled.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_valid", 64'(rd_valid), 64'd1);
                checkOutput("hold_data", rd_data, prev_data);
            end
            if (rd_valid && rd_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_pop: actual=%0h required=no word", rd_data);
                end else begin
                    checkOutput("pop_data", rd_data, sb.pop_front());
                end
            end
            stall_prev = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    initial begin
        int sent;
        int cyc;
        int exp_cnt;
        int prev_cnt;

        // Reset state
        do_reset(3);
        checkOutput("rst_valid", 64'(rd_valid), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_full", 64'(full), 64'd0);
        checkOutput("rst_almostfull", 64'(almostfull), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);

        // First-word latency: one write of 0xA5
        applyStimulus(1'b1, 64'hA5, 1'b0, 1'b1);
        wr_en = 1'b0;
        for (int k = 0; k <= L + 1; k++) begin
            checkOutput($sformatf("latency_valid_e%0d", k), 64'(rd_valid), 64'(k >= L + 1));
            checkOutput($sformatf("latency_count_e%0d", k), 64'(count), 64'd1);
            if (k < L + 1) wait_cycle();
        end
        checkOutput("latency_data", rd_data, 64'hA5);
        rd_ready = 1'b1;
        wait_cycle();
        rd_ready = 1'b0;
        checkOutput("latency_count_after_pop", 64'(count), 64'd0);
        checkOutput("latency_sb_left", 64'(sb.size()), 64'd0);

        // Fill past capacity with no reader, then drain in order
        do_reset(2);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 64'(i), 1'b0, i < CAP);
            exp_cnt  = (i + 1 < CAP) ? i + 1 : CAP;
            prev_cnt = (i < CAP) ? i : CAP;
            checkOutput($sformatf("fill_count_%0d", i), 64'(count), 64'(exp_cnt));
            checkOutput($sformatf("fill_almostfull_%0d", i), 64'(almostfull), 64'(prev_cnt > AF));
            checkOutput($sformatf("fill_full_%0d", i), 64'(full), 64'(i >= CAP - 1));
            checkOutput($sformatf("fill_overflow_%0d", i), 64'(overflow), 64'(i >= CAP));
        end
        wr_en = 1'b0;
        wait_cycle();
        checkOutput("fill_full_end", 64'(full), 64'd1);
        checkOutput("fill_count_end", 64'(count), 64'(CAP));
        checkOutput("fill_overflow_end", 64'(overflow), 64'd1);
`ifdef DISTRAM_FIFO_STATS_EN
        checkOutput("fill_drop_cnt", 64'(drop_cnt), 64'(40 - CAP));
        checkOutput("fill_peak_count", 64'(peak_count), 64'(CAP));
`endif
        drain("fill_drain", 200);
        checkOutput("fill_overflow_sticky", 64'(overflow), 64'd1);
        checkOutput("fill_full_after_drain", 64'(full), 64'd0);

        // Streaming: write and read every cycle
        do_reset(2);
        pops = 0;
        for (int c = 0; c < 1000; c++) begin
            applyStimulus(1'b1, 64'h5000 + 64'(c), 1'b1, 1'b1);
            if (c >= 100 && (c % 100) == 0) begin
                checkOutput($sformatf("stream_count_%0d", c), 64'(count), 64'(L + 2));
            end
        end
        checkOutput("stream_pops", 64'(pops), 64'(1000 - (L + 2)));
        drain("stream_drain", 50);

        // Backpressure: random reader stalls over 500 words
        do_reset(2);
        sent = 0;
        cyc  = 0;
        while (sent < 500 && cyc < 5000) begin
            if (sb.size() < 20 && $urandom_range(0, 3) != 0) begin
                applyStimulus(1'b1, 64'hB000_0000 + 64'(sent), 1'($urandom_range(0, 1)), 1'b1);
                sent++;
            end else begin
                applyStimulus(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
            end
            cyc++;
        end
        checkOutput("bp_sent", 64'(sent), 64'd500);
        drain("bp_drain", 200);

        // Three full fill/drain rounds to cross the pointer wrap
        do_reset(2);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < CAP; i++) begin
                applyStimulus(1'b1, 64'h100 * 64'(r + 1) + 64'(i), 1'b0, 1'b1);
            end
            wr_en = 1'b0;
            wait_cycle();
            checkOutput($sformatf("wrap_count_r%0d", r), 64'(count), 64'(CAP));
            checkOutput($sformatf("wrap_full_r%0d", r), 64'(full), 64'd1);
            checkOutput($sformatf("wrap_overflow_r%0d", r), 64'(overflow), 64'd0);
            checkOutput($sformatf("wrap_almostfull_r%0d", r), 64'(almostfull), 64'd1);
            drain($sformatf("wrap_drain_r%0d", r), 200);
        end

        // Mid-operation reset discards queued words
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 64'hDEAD_0000 + 64'(i), 1'b0, 1'b1);
        end
        wr_en = 1'b0;
        repeat (3) wait_cycle();
        do_reset(1);
        checkOutput("midrst_valid", 64'(rd_valid), 64'd0);
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_overflow", 64'(overflow), 64'd0);
        checkOutput("midrst_full", 64'(full), 64'd0);
        for (int k = 0; k < 5; k++) begin
            wait_cycle();
            checkOutput($sformatf("midrst_stale_%0d", k), 64'(rd_valid), 64'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b1);
        end
        drain("midrst_drain", 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
